// File: rtl/ahbl_gpio_irq.sv
// ahbl_gpio_irq -- AHB-Lite GPIO port with edge-triggered interrupts.
//
// WIDTH pins with per-pin direction, an output register with atomic
// set/clear/toggle aliases, and rising/falling edge detection into a
// sticky raw status register (write-1-to-clear).  The masked status is
// ORed into a single level interrupt.  Zero wait states.
//
// Ports
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   HADDR..HWDATA      AHB-Lite slave inputs (only HADDR[7:0] decoded)
//   HREADYOUT, HRDATA  AHB-Lite slave outputs
//   GPIO_IN            asynchronous pad inputs
//   GPIO_OUT, GPIO_OE  output data register and direction (1 = drive)
//   IRQ                |(RIS & IM)
//
// Register map (byte offset): 00 DATAI, 04 DATAO, 08 DIR, 0C SET, 10 CLR,
// 14 TGL, 18 IM, 1C IRE, 20 IFE, 24 RIS, 28 MIS, 2C ICR.  Write-only
// offsets read 0, unmapped offsets read 32'hBADDBEEF.

module ahbl_gpio_irq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic [2:0]       HSIZE,
  input  logic             HWRITE,
  input  logic             HSEL,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [7:0] OFF_DATAI = 8'h00;
  localparam logic [7:0] OFF_DATAO = 8'h04;
  localparam logic [7:0] OFF_DIR   = 8'h08;
  localparam logic [7:0] OFF_SET   = 8'h0C;
  localparam logic [7:0] OFF_CLR   = 8'h10;
  localparam logic [7:0] OFF_TGL   = 8'h14;
  localparam logic [7:0] OFF_IM    = 8'h18;
  localparam logic [7:0] OFF_IRE   = 8'h1C;
  localparam logic [7:0] OFF_IFE   = 8'h20;
  localparam logic [7:0] OFF_RIS   = 8'h24;
  localparam logic [7:0] OFF_MIS   = 8'h28;
  localparam logic [7:0] OFF_ICR   = 8'h2C;

  // Held address-phase signals
  logic [7:0] addr_q;
  logic       trans_q;
  logic       write_q;
  logic       sel_q;

  // Input synchroniser chain and previous-value flop for edge detection
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_top;

  // Programmer-visible registers
  logic [WIDTH-1:0] datao_q, datao_d;
  logic [WIDTH-1:0] dir_q,   dir_d;
  logic [WIDTH-1:0] im_q,    im_d;
  logic [WIDTH-1:0] ire_q,   ire_d;
  logic [WIDTH-1:0] ife_q,   ife_d;
  logic [WIDTH-1:0] ris_q,   ris_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] icr_clr;
  logic [WIDTH-1:0] evt;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA};

  function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
    ext = '0;
    ext[WIDTH-1:0] = v;
  endfunction

  assign wr_en    = trans_q & sel_q & write_q;
  assign wdata    = HWDATA[WIDTH-1:0];
  assign sync_top = sync_q[SYNC_STAGES-1];
  assign evt      = (sync_top & ~prev_q & ire_q) | (~sync_top & prev_q & ife_q);

  always_comb begin
    datao_d = datao_q;
    dir_d   = dir_q;
    im_d    = im_q;
    ire_d   = ire_q;
    ife_d   = ife_q;
    icr_clr = '0;
    if (wr_en) begin
      case (addr_q)
        OFF_DATAO: datao_d = wdata;
        OFF_DIR:   dir_d   = wdata;
        OFF_SET:   datao_d = datao_q | wdata;
        OFF_CLR:   datao_d = datao_q & ~wdata;
        OFF_TGL:   datao_d = datao_q ^ wdata;
        OFF_IM:    im_d    = wdata;
        OFF_IRE:   ire_d   = wdata;
        OFF_IFE:   ife_d   = wdata;
        OFF_ICR:   icr_clr = wdata;
        default:   ;
      endcase
    end
    // Clear first, then OR in new events so a coincident edge wins.
    ris_d = (ris_q & ~icr_clr) | evt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      trans_q <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= 1'b0;
      sync_q  <= '0;
      prev_q  <= '0;
      datao_q <= '0;
      dir_q   <= '0;
      im_q    <= '0;
      ire_q   <= '0;
      ife_q   <= '0;
      ris_q   <= '0;
    end else begin
      if (HREADY) begin
        addr_q  <= HADDR[7:0];
        trans_q <= HTRANS[1];
        write_q <= HWRITE;
        sel_q   <= HSEL;
      end
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], GPIO_IN};
      end else begin
        sync_q <= GPIO_IN;
      end
      prev_q  <= sync_top;
      datao_q <= datao_d;
      dir_q   <= dir_d;
      im_q    <= im_d;
      ire_q   <= ire_d;
      ife_q   <= ife_d;
      ris_q   <= ris_d;
    end
  end

  always_comb begin
    HRDATA = 32'hBADDBEEF;
    case (addr_q)
      OFF_DATAI: HRDATA = ext(sync_top);
      OFF_DATAO: HRDATA = ext(datao_q);
      OFF_DIR:   HRDATA = ext(dir_q);
      OFF_SET,
      OFF_CLR,
      OFF_TGL,
      OFF_ICR:   HRDATA = '0;
      OFF_IM:    HRDATA = ext(im_q);
      OFF_IRE:   HRDATA = ext(ire_q);
      OFF_IFE:   HRDATA = ext(ife_q);
      OFF_RIS:   HRDATA = ext(ris_q);
      OFF_MIS:   HRDATA = ext(ris_q & im_q);
      default:   ;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign GPIO_OUT  = datao_q;
  assign GPIO_OE   = dir_q;
  assign IRQ       = |(ris_q & im_q);

endmodule

// File: tb/tb_ahbl_gpio_irq.sv
// Bench for ahbl_gpio_irq: a 32-pin and an 8-pin instance share one bus.
// A cycle-indexed reference model predicts read data, which is queued and
// checked by an independent monitor when it sees a read data phase.

module tb_ahbl_gpio_irq;
  localparam int S = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HREADY = 1'b1;
  logic [2:0]  HSIZE = 3'b010;
  logic        HWRITE = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HWDATA = '0;
  logic [31:0] GPIO_IN = '0;

  logic        HREADYOUT, HREADYOUT8;
  logic [31:0] HRDATA, HRDATA8;
  logic [31:0] GPIO_OUT, GPIO_OE;
  logic [7:0]  GPIO_OUT8, GPIO_OE8;
  logic        IRQ, IRQ8;

  always #5 HCLK = ~HCLK;

  ahbl_gpio_irq #(.WIDTH(32), .SYNC_STAGES(S)) u_w32 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ));

  ahbl_gpio_irq #(.WIDTH(8), .SYNC_STAGES(S)) u_w8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT8), .HRDATA(HRDATA8),
    .GPIO_IN(GPIO_IN[7:0]), .GPIO_OUT(GPIO_OUT8), .GPIO_OE(GPIO_OE8), .IRQ(IRQ8));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_dato = '0, m_dir = '0, m_im = '0, m_ire = '0, m_ife = '0, m_ris = '0;
  logic        pend_v = 1'b0, pend_w = 1'b0;
  logic [7:0]  pend_a = '0;
  int          cyc = 0, rst_cyc = 0;
  logic [31:0] smp [int];

  typedef struct {
    logic [7:0]  a;
    logic [31:0] e32;
    logic [31:0] e8;
  } rd_t;
  rd_t sbq[$];

  // GPIO_IN value sampled at clock edge k (zero before the last reset)
  function automatic logic [31:0] samp(input int k);
    if (k <= rst_cyc || !smp.exists(k)) return '0;
    return smp[k];
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a, input logic [31:0] mask);
    case (a)
      8'h00: return samp(cyc - (S - 1)) & mask;
      8'h04: return m_dato & mask;
      8'h08: return m_dir & mask;
      8'h18: return m_im & mask;
      8'h1C: return m_ire & mask;
      8'h20: return m_ife & mask;
      8'h24: return m_ris & mask;
      8'h28: return m_ris & m_im & mask;
      8'h0C, 8'h10, 8'h14, 8'h2C: return '0;
      default: return 32'hBADDBEEF;
    endcase
  endfunction

  initial forever begin
    logic [31:0] cur, prv, ev, clr;
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      m_dato = '0; m_dir = '0; m_im = '0; m_ire = '0; m_ife = '0; m_ris = '0;
      pend_v = 1'b0; pend_w = 1'b0; pend_a = '0;
      rst_cyc = cyc;
      sbq.delete();
    end else begin
      cyc++;
      smp[cyc] = GPIO_IN;
      cur = samp(cyc - S);
      prv = samp(cyc - S - 1);
      ev  = (cur & ~prv & m_ire) | (~cur & prv & m_ife);
      clr = '0;
      if (pend_v && pend_w) begin
        case (pend_a)
          8'h04: m_dato = HWDATA;
          8'h08: m_dir  = HWDATA;
          8'h0C: m_dato = m_dato | HWDATA;
          8'h10: m_dato = m_dato & ~HWDATA;
          8'h14: m_dato = m_dato ^ HWDATA;
          8'h18: m_im   = HWDATA;
          8'h1C: m_ire  = HWDATA;
          8'h20: m_ife  = HWDATA;
          8'h2C: clr    = HWDATA;
          default: ;
        endcase
      end
      m_ris = (m_ris & ~clr) | ev;
      if (HREADY) begin
        pend_v = HSEL & HTRANS[1];
        pend_w = HWRITE;
        pend_a = HADDR[7:0];
        if (pend_v && !pend_w)
          sbq.push_back('{pend_a, m_read(pend_a, 32'hFFFF_FFFF), m_read(pend_a, 32'h0000_00FF)});
      end
    end
  end

  // ---------------- monitor ----------------
  logic rd_ph = 1'b0;
  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) rd_ph = 1'b0;
    else          rd_ph = HREADY & HSEL & HTRANS[1] & ~HWRITE;
  end

  initial forever begin
    rd_t e;
    @(negedge HCLK);
    if (HRESETn) begin
      if (rd_ph) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: read data phase with no expected entry at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("hrdata32@%h", e.a), HRDATA, e.e32);
          chk($sformatf("hrdata8@%h", e.a), HRDATA8, e.e8);
        end
      end
      chk("gpio_out32", GPIO_OUT, m_dato);
      chk("gpio_oe32", GPIO_OE, m_dir);
      chk("gpio_out8", {24'h0, GPIO_OUT8}, m_dato & 32'hFF);
      chk("gpio_oe8", {24'h0, GPIO_OE8}, m_dir & 32'hFF);
      chk("irq32", {31'h0, IRQ}, {31'h0, |(m_ris & m_im)});
      chk("irq8", {31'h0, IRQ8}, {31'h0, |(m_ris & m_im & 32'hFF)});
      chk("hreadyout", {30'h0, HREADYOUT, HREADYOUT8}, 32'h3);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wd_pend = '0;

  task automatic cyc_drive(input logic [1:0] tr, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input bit sel);
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = a;
    HWDATA = wd_pend;
    @(posedge HCLK);
    #1;
    wd_pend = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc_drive(2'b10, 1'b1, a, d, 1'b1);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc_drive(2'b10, 1'b0, a, '0, 1'b1);
  endtask
  task automatic idle();
    cyc_drive(2'b00, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [7:0] offs [16];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
             8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'hFC, 8'h01};

    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_out", GPIO_OUT, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    @(posedge HCLK);
    #1;

    // Reset values of every offset
    for (int i = 0; i < 14; i++) rd({24'h0, offs[i]});
    idle();

    // Atomic output operations, then back-to-back read
    wr(32'h04, 32'h0000_00F0);
    wr(32'h0C, 32'h0000_000F);
    wr(32'h10, 32'h0000_0030);
    wr(32'h14, 32'h8000_0001);
    rd(32'h04);
    idle();
    chk("atomic_out", GPIO_OUT, 32'h8000_00CE);

    // Bits above WIDTH are dropped on the 8-pin instance
    wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h04);
    idle();
    chk("w8_out", {24'h0, GPIO_OUT8}, 32'h0000_00FF);

    // Rising edge on bit 0 with exact latency
    wr(32'h1C, 32'h1);
    wr(32'h18, 32'h1);
    idle();
    idle();
    GPIO_IN[0] = 1'b1;
    repeat (S) @(posedge HCLK);
    #1;
    chk("rise_irq_early", {31'h0, IRQ}, 32'h0);
    @(posedge HCLK);
    #1;
    chk("rise_irq", {31'h0, IRQ}, 32'h1);
    rd(32'h24);
    rd(32'h28);
    wr(32'h2C, 32'h1);
    idle();
    chk("icr_irq", {31'h0, IRQ}, 32'h0);

    // Falling edge on bit 2, masked then unmasked
    wr(32'h18, 32'h0);
    idle();
    GPIO_IN[2] = 1'b1;
    repeat (4) idle();
    wr(32'h20, 32'h4);
    idle();
    GPIO_IN[2] = 1'b0;
    repeat (4) idle();
    rd(32'h24);
    rd(32'h28);
    idle();
    chk("fall_masked_irq", {31'h0, IRQ}, 32'h0);
    wr(32'h18, 32'h4);
    idle();
    chk("fall_unmasked_irq", {31'h0, IRQ}, 32'h1);

    // Rising edge on bit 3 coinciding with an ICR clear of bit 3
    wr(32'h2C, 32'hFFFF_FFFF);
    wr(32'h1C, 32'h8);
    wr(32'h18, 32'h8);
    idle();
    idle();
    GPIO_IN[3] = 1'b1;
    @(posedge HCLK);
    #1;
    wr(32'h2C, 32'h8);
    idle();
    chk("set_wins_irq", {31'h0, IRQ}, 32'h1);
    rd(32'h24);
    wr(32'h2C, 32'h8);
    idle();
    chk("clear_irq", {31'h0, IRQ}, 32'h0);

    // Asynchronous reset in the middle of a cycle
    wr(32'h08, 32'h0000_FFFF);
    GPIO_IN[3] = 1'b0;
    idle();
    idle();
    GPIO_IN[3] = 1'b1;
    repeat (4) idle();
    chk("pre_rst_irq", {31'h0, IRQ}, 32'h1);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("arst_out32", GPIO_OUT, 32'h0);
    chk("arst_oe32", GPIO_OE, 32'h0);
    chk("arst_irq32", {31'h0, IRQ}, 32'h0);
    chk("arst_out8", {24'h0, GPIO_OUT8}, 32'h0);
    chk("arst_oe8", {24'h0, GPIO_OE8}, 32'h0);
    chk("arst_irq8", {31'h0, IRQ8}, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle();

    // Randomised traffic and pin activity
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] hi, d, r;
      logic [7:0]  off;
      hi  = $urandom();
      d   = $urandom();
      r   = $urandom();
      off = offs[$urandom_range(0, 15)];
      if ($urandom_range(0, 2) == 0) GPIO_IN = GPIO_IN ^ ($urandom() & $urandom());
      if ($urandom_range(0, 4) == 0)
        cyc_drive({1'b0, r[0]}, r[1], {hi[31:8], off}, d, r[2]);
      else
        cyc_drive({1'b1, r[0]}, r[1], {hi[31:8], off}, d, ($urandom_range(0, 9) != 0));
    end
    idle();
    idle();
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_gpio_irq.md
# ahbl_gpio_irq

Parametrised AHB-Lite GPIO port with WIDTH pins, per-pin direction, atomic set/clear/toggle of the output register, and edge-triggered interrupts (rising/falling, per-pin enable and mask, write-1-to-clear). Sits on the AHB-Lite peripheral bus next to the other AHB-Lite slaves. Drives one level interrupt line to the CPU interrupt controller.

## Interface
- WIDTH, 32, number of GPIO pins, 1..32; register bits above WIDTH-1 read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth, >= 2
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HADDR  in  32  address; only HADDR[7:0] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 is an active transfer
- HREADY  in  1  bus ready; address phase captured only when 1
- HSIZE  in  3  captured, unused; every access treated as 32-bit
- HWRITE  in  1  1 = write
- HSEL  in  1  slave select
- HWDATA  in  32  write data, data phase
- HREADYOUT  out  1  constant 1, zero wait states
- HRDATA  out  32  read data, data phase
- GPIO_IN  in  WIDTH  asynchronous pad inputs
- GPIO_OUT  out  WIDTH  = DATAO
- GPIO_OE  out  WIDTH  = DIR, 1 = output enabled
- IRQ  out  1  = |(RIS & IM)

## Operation
- Address phase: HADDR, HTRANS, HWRITE, HSEL registered when HREADY=1; these held copies are cleared by reset.
- Write strobe: held HTRANS[1] & HSEL & HWRITE. Register updates at the end of the data phase from HWDATA[WIDTH-1:0].
- Register map (byte offset, access, reset value):
  - 0x00 DATAI, RO, 0: synchronised GPIO_IN
  - 0x04 DATAO, RW, 0
  - 0x08 DIR, RW, 0
  - 0x0C SET, WO: DATAO |= wdata
  - 0x10 CLR, WO: DATAO &= ~wdata
  - 0x14 TGL, WO: DATAO ^= wdata
  - 0x18 IM, RW, 0: interrupt mask, 1 = enabled
  - 0x1C IRE, RW, 0: rising-edge detect enable
  - 0x20 IFE, RW, 0: falling-edge detect enable
  - 0x24 RIS, RO, 0: raw interrupt status
  - 0x28 MIS, RO: RIS & IM
  - 0x2C ICR, WO: RIS &= ~wdata
- Reads of WO offsets return 0. Reads of unmapped offsets return 32'hBADDBEEF. Reads have no side effects.
- HRDATA is combinational from the held address and current register state.
- Synchroniser: SYNC_STAGES flops (reset 0), then a PREV flop (reset 0).
  - rise = SYNC & ~PREV; fall = ~SYNC & PREV.
  - event[i] = (rise[i] & IRE[i]) | (fall[i] & IFE[i]), evaluated in the cycle the edge is in SYNC.
- RIS[i] is set by event[i] and cleared only by an ICR write with bit i = 1.
- Simultaneous event and ICR clear on the same bit in the same cycle: set wins, RIS stays 1.
- Changing IRE, IFE or IM never alters RIS. IM gates IRQ only.
- Edges are not queued: multiple events on a bit before clear leave RIS = 1.
- Reset asserted mid-operation: all registers and flops return to their reset values immediately (asynchronous); IRQ = 0 and GPIO_OUT = GPIO_OE = 0 while HRESETn = 0.

## Timing
- Reset values: HREADYOUT 1, GPIO_OUT 0, GPIO_OE 0, IRQ 0. HRDATA decodes to DATAI = 0 (held address reset to 0).
- Write: register value visible on GPIO_OUT / GPIO_OE / IRQ one cycle after the data phase clock edge.
- Read-after-write to the same register in back-to-back transfers returns the new value.
- Input latency: GPIO_IN change sampled at edge N appears in DATAI after edge N+SYNC_STAGES-1. The corresponding RIS bit and IRQ are set after edge N+SYNC_STAGES.
- ICR write: RIS bit and IRQ drop one edge after the data phase (unless a new event coincides).
- Pulses on GPIO_IN shorter than one HCLK period may be missed. No guarantee is given for them.

## Test plan
- Reset: after HRESETn release, read all offsets -> 0x0 for DATAI..MIS, 0 for WO offsets, 0xBADDBEEF at 0x40; GPIO_OUT = 0, GPIO_OE = 0, IRQ = 0.
- Atomic ops (WIDTH = 32): write DATAO = 0x0000_00F0, SET 0x0F, CLR 0x30, TGL 0x8000_0001 -> GPIO_OUT ends 0x8000_00CE; DATAO read-back matches.
- Rising edge: IRE = 0x1, IM = 0x1; drive GPIO_IN[0] 0->1 -> IRQ = 1 exactly SYNC_STAGES+1 edges later, RIS = MIS = 0x1. ICR = 0x1 -> IRQ = 0 next cycle.
- Falling edge and masking: IFE = 0x4, IM = 0; drive GPIO_IN[2] 1->0 -> RIS = 0x4, MIS = 0, IRQ = 0. Write IM = 0x4 -> IRQ = 1.
- Set-wins collision: align a rising edge on bit 3 with an ICR write of 0x8 in the same cycle -> RIS[3] stays 1.
- Parametrisation: WIDTH = 8; write DATAO = 0xFFFF_FFFF -> read 0x0000_00FF, GPIO_OUT = 0xFF. Mid-test HRESETn pulse -> all outputs 0 immediately.
